// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the MiniRiscV decode stage.
//   XLEN / NREG / REG_AW : datapath width, register count, register index width
//   OP_*                 : the nine base opcodes this core decodes
//   imm_fmt_e            : which immediate layout an instruction uses
//   idex_t               : contents of the ID/EX pipeline register
//   gen_imm()            : builds the sign-extended immediate for a format
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = $clog2(NREG);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              mem_read;
        logic              illegal;
    } idex_t;

    // B and J immediates carry an implicit zero LSB; U places its field in
    // the upper 20 bits and is never sign-extended.
    function automatic logic [XLEN-1:0] gen_imm(input logic [XLEN-1:0] inst,
                                                input imm_fmt_e        fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/inst_decode_if.sv
// ---------------------------------------------------------------------------
// inst_decode_if
// Bundles the decode stage's fetch-side, write-back and ID/EX signals.
//   master : fetch / write-back / execute side (drives inst, pc_in, flush,
//            wb_*, observes stall and the ID/EX register)
//   slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface inst_decode_if;
    import riscv_pkg::*;

    logic [XLEN-1:0]   inst;
    logic [XLEN-1:0]   pc_in;
    logic              flush;
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;

    logic              stall;
    logic              valid_out;
    logic [XLEN-1:0]   pc_out;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm32;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7b5;
    logic              mem_read;
    logic              illegal;

    modport master (
        output inst, pc_in, flush, wb_en, wb_addr, wb_data,
        input  stall, valid_out, pc_out, rs1_data, rs2_data, imm32,
               rd, opcode, funct3, funct7b5, mem_read, illegal
    );

    modport slave (
        input  inst, pc_in, flush, wb_en, wb_addr, wb_data,
        output stall, valid_out, pc_out, rs1_data, rs2_data, imm32,
               rd, opcode, funct3, funct7b5, mem_read, illegal
    );

endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 32 x XLEN architectural register file, two read ports and one write port.
//   clk, rst              : clock, synchronous active-high clear of all regs
//   rs1_addr_i/rs2_addr_i : read indices
//   rs1_data_o/rs2_data_o : read data (x0 reads zero, write-first bypass)
//   wb_en_i/wb_addr_i/wb_data_i : write-back port (x0 writes dropped)
// ---------------------------------------------------------------------------
module reg_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_en;

    assign wr_en = wb_en_i && (wb_addr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    // Write-first: a same-cycle write to the register being read is
    // forwarded so decode never sees the stale value.
    always_comb begin
        rs1_data_o = regs_q[rs1_addr_i];
        if (rs1_addr_i == '0) begin
            rs1_data_o = '0;
        end else if (wr_en && (wb_addr_i == rs1_addr_i)) begin
            rs1_data_o = wb_data_i;
        end
    end

    always_comb begin
        rs2_data_o = regs_q[rs2_addr_i];
        if (rs2_addr_i == '0) begin
            rs2_data_o = '0;
        end else if (wr_en && (wb_addr_i == rs2_addr_i)) begin
            rs2_data_o = wb_data_i;
        end
    end

endmodule

// File: rtl/inst_decode.sv
// ---------------------------------------------------------------------------
// inst_decode
// ID stage of the MiniRiscV pipeline: decodes the fetched instruction, reads
// operands from the register file, builds the immediate, detects load-use
// hazards and registers everything into the ID/EX pipeline register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : inst_decode_if.slave
//              in : inst, pc_in, flush, wb_en, wb_addr, wb_data
//              out: stall (combinational), valid_out, pc_out, rs1_data,
//                   rs2_data, imm32, rd, opcode, funct3, funct7b5,
//                   mem_read, illegal (all registered)
// ---------------------------------------------------------------------------
module inst_decode
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    inst_decode_if.slave bus
);

    logic [6:0]        opcode_w;
    logic [REG_AW-1:0] rs1_addr_w;
    logic [REG_AW-1:0] rs2_addr_w;
    logic [REG_AW-1:0] rd_addr_w;
    logic [XLEN-1:0]   rs1_rd_w;
    logic [XLEN-1:0]   rs2_rd_w;

    logic              legal_w;
    logic              uses_rs1_w;
    logic              uses_rs2_w;
    logic              is_load_w;
    imm_fmt_e          fmt_w;

    logic              rs1_hit_w;
    logic              rs2_hit_w;
    logic              stall_w;

    idex_t             idex_q;
    idex_t             idex_d;

    assign opcode_w   = bus.inst[6:0];
    assign rd_addr_w  = bus.inst[11:7];
    assign rs1_addr_w = bus.inst[19:15];
    assign rs2_addr_w = bus.inst[24:20];

    reg_file u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (rs1_addr_w),
        .rs2_addr_i (rs2_addr_w),
        .wb_en_i    (bus.wb_en),
        .wb_addr_i  (bus.wb_addr),
        .wb_data_i  (bus.wb_data),
        .rs1_data_o (rs1_rd_w),
        .rs2_data_o (rs2_rd_w)
    );

    // Opcode classification: legality, operand usage and immediate layout.
    always_comb begin
        legal_w    = 1'b1;
        uses_rs1_w = 1'b0;
        uses_rs2_w = 1'b0;
        is_load_w  = 1'b0;
        fmt_w      = IMM_NONE;
        case (opcode_w)
            OP_R: begin
                uses_rs1_w = 1'b1;
                uses_rs2_w = 1'b1;
            end
            OP_IMM: begin
                uses_rs1_w = 1'b1;
                fmt_w      = IMM_I;
            end
            OP_LOAD: begin
                uses_rs1_w = 1'b1;
                is_load_w  = 1'b1;
                fmt_w      = IMM_I;
            end
            OP_STORE: begin
                uses_rs1_w = 1'b1;
                uses_rs2_w = 1'b1;
                fmt_w      = IMM_S;
            end
            OP_BRANCH: begin
                uses_rs1_w = 1'b1;
                uses_rs2_w = 1'b1;
                fmt_w      = IMM_B;
            end
            OP_JALR: begin
                uses_rs1_w = 1'b1;
                fmt_w      = IMM_I;
            end
            OP_JAL:   fmt_w = IMM_J;
            OP_LUI:   fmt_w = IMM_U;
            OP_AUIPC: fmt_w = IMM_U;
            default:  legal_w = 1'b0;
        endcase
    end

    // Only an operand the instruction actually reads can create a hazard,
    // so immediate bits sitting in the rs1/rs2 fields are ignored.
    assign rs1_hit_w = uses_rs1_w && (rs1_addr_w == idex_q.rd);
    assign rs2_hit_w = uses_rs2_w && (rs2_addr_w == idex_q.rd);

    assign stall_w = !rst && !bus.flush && idex_q.valid && idex_q.mem_read &&
                     (idex_q.rd != '0) && (rs1_hit_w || rs2_hit_w);

    // Flush or stall inserts an all-zero bubble; an illegal opcode keeps the
    // entry invalid with rd forced to x0 so it can neither write back nor
    // trigger a hazard downstream.
    always_comb begin
        idex_d = '0;
        if (!bus.flush && !stall_w) begin
            idex_d.valid    = legal_w;
            idex_d.illegal  = !legal_w;
            idex_d.pc       = bus.pc_in;
            idex_d.rs1_data = rs1_rd_w;
            idex_d.rs2_data = rs2_rd_w;
            idex_d.imm      = gen_imm(bus.inst, fmt_w);
            idex_d.rd       = legal_w ? rd_addr_w : '0;
            idex_d.opcode   = opcode_w;
            idex_d.funct3   = bus.inst[14:12];
            idex_d.funct7b5 = bus.inst[30];
            idex_d.mem_read = legal_w && is_load_w;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.stall     = stall_w;
    assign bus.valid_out = idex_q.valid;
    assign bus.pc_out    = idex_q.pc;
    assign bus.rs1_data  = idex_q.rs1_data;
    assign bus.rs2_data  = idex_q.rs2_data;
    assign bus.imm32     = idex_q.imm;
    assign bus.rd        = idex_q.rd;
    assign bus.opcode    = idex_q.opcode;
    assign bus.funct3    = idex_q.funct3;
    assign bus.funct7b5  = idex_q.funct7b5;
    assign bus.mem_read  = idex_q.mem_read;
    assign bus.illegal   = idex_q.illegal;

endmodule

// File: tb/tb_inst_decode.sv
// ---------------------------------------------------------------------------
// tb_inst_decode
// Self-checking bench for inst_decode: directed scenarios plus a randomized
// run compared against a behavioural model of the decode stage.
// ---------------------------------------------------------------------------
module tb_inst_decode;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_decode_if dif ();

    inst_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: register contents and the expected ID/EX entry.
    logic [31:0] mregs [32];
    logic        m_valid, m_illegal, m_mem_read, m_f7b5, m_use1, m_use2;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_op;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [6:0]  legal_ops [9];

    function automatic void classify(input logic [6:0] op, output bit legal,
                                     output bit u1, output bit u2, output bit ld);
        legal = 1; u1 = 0; u2 = 0; ld = 0;
        case (op)
            OP_R, OP_STORE, OP_BRANCH: begin u1 = 1; u2 = 1; end
            OP_IMM, OP_JALR:           u1 = 1;
            OP_LOAD:                   begin u1 = 1; ld = 1; end
            OP_JAL, OP_LUI, OP_AUIPC:  ;
            default:                   legal = 0;
        endcase
    endfunction

    // Immediate value computed arithmetically from the field weights.
    function automatic logic [31:0] model_imm(input logic [31:0] w);
        longint v;
        v = 0;
        case (w[6:0])
            OP_IMM, OP_LOAD, OP_JALR: v = longint'(w[31:20]) - (w[31] ? 4096 : 0);
            OP_STORE:  v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 4096 : 0);
            OP_BRANCH: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 +
                           longint'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
            OP_JAL:    v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 +
                           longint'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
            OP_LUI, OP_AUIPC: v = longint'(w[31:12]) * 4096;
            default:   v = 0;
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (dif.wb_en && dif.wb_addr == a) return dif.wb_data;
        return mregs[a];
    endfunction

    function automatic bit model_stall();
        bit legal, u1, u2, ld;
        if (rst || dif.flush) return 0;
        classify(dif.inst[6:0], legal, u1, u2, ld);
        return m_valid && m_mem_read && (m_rd != 0) &&
               ((u1 && dif.inst[19:15] == m_rd) || (u2 && dif.inst[24:20] == m_rd));
    endfunction

    // Advance one clock edge and move the model forward with it.
    task automatic tick();
        bit legal, u1, u2, ld, st;
        logic [31:0] r1, r2;
        st = model_stall();
        classify(dif.inst[6:0], legal, u1, u2, ld);
        r1 = mread(dif.inst[19:15]);
        r2 = mread(dif.inst[24:20]);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        end else if (dif.wb_en && dif.wb_addr != 0) begin
            mregs[dif.wb_addr] = dif.wb_data;
        end
        m_valid = 0; m_illegal = 0; m_mem_read = 0; m_rd = 0; m_pc = 0;
        m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_op = 0; m_f3 = 0; m_f7b5 = 0;
        m_use1 = 0; m_use2 = 0;
        if (!rst && !dif.flush && !st) begin
            m_valid    = legal;
            m_illegal  = !legal;
            m_mem_read = legal && ld;
            m_rd       = legal ? dif.inst[11:7] : 5'd0;
            m_pc       = dif.pc_in;
            m_rs1      = r1;
            m_rs2      = r2;
            m_imm      = model_imm(dif.inst);
            m_op       = dif.inst[6:0];
            m_f3       = dif.inst[14:12];
            m_f7b5     = dif.inst[30];
            m_use1     = u1;
            m_use2     = u2;
        end
    endtask

    task automatic set_in(input logic [31:0] i, input logic [31:0] p, input logic f,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        dif.inst = i; dif.pc_in = p; dif.flush = f;
        dif.wb_en = we; dif.wb_addr = wa; dif.wb_data = wd;
        #1;
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    task automatic test_reset();
        rst = 1;
        set_in(32'h0, 32'h0, 0, 0, 0, 0);
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", dif.stall); end
        tick();
        tick();
        checks++; if (dif.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", dif.valid_out); end
        checks++; if (dif.illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b want 0", dif.illegal); end
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall_hold: got %b want 0", dif.stall); end
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            set_in(enc_r(5'd1, 5'(i), 5'(31 - i)), 32'h100 + 32'(i * 4), 0, 0, 0, 0);
            tick();
            checks++; if (dif.rs1_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rs1[x%0d]: got %h want 0", i, dif.rs1_data); end
            checks++; if (dif.rs2_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rs2[x%0d]: got %h want 0", 31 - i, dif.rs2_data); end
        end
    endtask

    task automatic test_bypass();
        set_in(enc_r(5'd1, 5'd5, 5'd0), 32'h200, 0, 1, 5'd5, 32'hDEADBEEF);
        tick();
        checks++; if (dif.rs1_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bypass_rs1: got %h want deadbeef", dif.rs1_data); end
        checks++; if (dif.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL bypass_valid: got %b want 1", dif.valid_out); end
        checks++; if (dif.pc_out !== 32'h200) begin errors++; $display("[TB] FAIL bypass_pc: got %h want 200", dif.pc_out); end
        set_in(enc_i(OP_IMM, 5'd0, 5'd0, 12'h0), 32'h204, 0, 1, 5'd0, 32'h1234);
        tick();
        set_in(enc_r(5'd1, 5'd0, 5'd5), 32'h208, 0, 0, 0, 0);
        tick();
        checks++; if (dif.rs1_data !== 32'h0) begin errors++; $display("[TB] FAIL x0_read: got %h want 0", dif.rs1_data); end
        checks++; if (dif.rs2_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL x5_retained: got %h want deadbeef", dif.rs2_data); end
    endtask

    task automatic test_immediates();
        set_in(enc_s(5'd1, 5'd2, 12'hFF8), 32'h300, 0, 0, 0, 0);
        tick();
        checks++; if (dif.imm32 !== 32'hFFFFFFF8) begin errors++; $display("[TB] FAIL imm_sw: got %h want fffffff8", dif.imm32); end
        set_in(enc_b(5'd1, 5'd2, 13'd16), 32'h304, 0, 0, 0, 0);
        tick();
        checks++; if (dif.imm32 !== 32'h00000010) begin errors++; $display("[TB] FAIL imm_beq: got %h want 00000010", dif.imm32); end
        set_in({20'hABCDE, 5'd7, OP_LUI}, 32'h308, 0, 0, 0, 0);
        tick();
        checks++; if (dif.imm32 !== 32'hABCDE000) begin errors++; $display("[TB] FAIL imm_lui: got %h want abcde000", dif.imm32); end
        checks++; if (dif.rd !== 5'd7) begin errors++; $display("[TB] FAIL lui_rd: got %0d want 7", dif.rd); end
        set_in(enc_j(5'd1, 21'h1FFFFC), 32'h30C, 0, 0, 0, 0);
        tick();
        checks++; if (dif.imm32 !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL imm_jal: got %h want fffffffc", dif.imm32); end
    endtask

    task automatic test_load_use();
        set_in(enc_i(OP_LOAD, 5'd3, 5'd1, 12'h0), 32'h400, 0, 0, 0, 0);
        tick();
        checks++; if (dif.mem_read !== 1'b1) begin errors++; $display("[TB] FAIL lw_mem_read: got %b want 1", dif.mem_read); end
        set_in(enc_r(5'd4, 5'd3, 5'd2), 32'h404, 0, 0, 0, 0);
        checks++; if (dif.stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall: got %b want 1", dif.stall); end
        tick();
        checks++; if (dif.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_valid: got %b want 0", dif.valid_out); end
        checks++; if (dif.mem_read !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble_mem_read: got %b want 0", dif.mem_read); end
        set_in(enc_r(5'd4, 5'd3, 5'd2), 32'h404, 0, 0, 0, 0);
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_clear: got %b want 0", dif.stall); end
        tick();
        checks++; if (dif.valid_out !== 1'b1) begin errors++; $display("[TB] FAIL lu_issue_valid: got %b want 1", dif.valid_out); end
        checks++; if (dif.rd !== 5'd4) begin errors++; $display("[TB] FAIL lu_issue_rd: got %0d want 4", dif.rd); end
        // Load to x0 followed by a reader of x0 must not stall.
        set_in(enc_i(OP_LOAD, 5'd0, 5'd1, 12'h0), 32'h408, 0, 0, 0, 0);
        tick();
        set_in(enc_r(5'd4, 5'd0, 5'd0), 32'h40C, 0, 0, 0, 0);
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("[TB] FAIL lw_x0_stall: got %b want 0", dif.stall); end
        tick();
    endtask

    task automatic test_flush_priority();
        set_in(enc_i(OP_LOAD, 5'd3, 5'd1, 12'h0), 32'h500, 0, 0, 0, 0);
        tick();
        set_in(enc_r(5'd4, 5'd3, 5'd2), 32'h504, 1, 0, 0, 0);
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b want 0", dif.stall); end
        tick();
        checks++; if (dif.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b want 0", dif.valid_out); end
        checks++; if (dif.pc_out !== 32'h0) begin errors++; $display("[TB] FAIL flush_pc: got %h want 0", dif.pc_out); end
    endtask

    task automatic test_illegal();
        set_in(32'hFFFFFFFF, 32'h600, 0, 0, 0, 0);
        tick();
        checks++; if (dif.illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %b want 1", dif.illegal); end
        checks++; if (dif.valid_out !== 1'b0) begin errors++; $display("[TB] FAIL illegal_valid: got %b want 0", dif.valid_out); end
        checks++; if (dif.rd !== 5'd0) begin errors++; $display("[TB] FAIL illegal_rd: got %0d want 0", dif.rd); end
        set_in(enc_r(5'd9, 5'd1, 5'd2), 32'h604, 0, 0, 0, 0);
        tick();
        checks++; if (dif.illegal !== 1'b0) begin errors++; $display("[TB] FAIL illegal_clears: got %b want 0", dif.illegal); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        bit          keep;
        keep = 0;
        w = 32'h0;
        for (int n = 0; n < 400; n++) begin
            if (!keep) begin
                int k;
                w = $urandom;
                k = $urandom_range(0, 11);
                if (k < 9) w[6:0] = legal_ops[k];
                else if (k < 11) w[6:0] = OP_LOAD;
                if ($urandom_range(0, 1) == 1) begin
                    w[11:7]  = 5'($urandom_range(0, 3));
                    w[19:15] = 5'($urandom_range(0, 3));
                    w[24:20] = 5'($urandom_range(0, 3));
                end
            end
            set_in(w, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                   5'($urandom_range(0, 31)), $urandom);
            keep = model_stall();
            checks++; if (dif.stall !== keep) begin errors++; $display("[TB] FAIL rnd_stall[%0d]: got %b want %b", n, dif.stall, keep); end
            tick();
            checks++; if (dif.valid_out !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b want %b", n, dif.valid_out, m_valid); end
            checks++; if (dif.illegal !== m_illegal) begin errors++; $display("[TB] FAIL rnd_illegal[%0d]: got %b want %b", n, dif.illegal, m_illegal); end
            checks++; if (dif.mem_read !== m_mem_read) begin errors++; $display("[TB] FAIL rnd_mem_read[%0d]: got %b want %b", n, dif.mem_read, m_mem_read); end
            checks++; if (dif.rd !== m_rd) begin errors++; $display("[TB] FAIL rnd_rd[%0d]: got %0d want %0d", n, dif.rd, m_rd); end
            if (m_valid || !m_illegal) begin
                checks++; if (dif.pc_out !== m_pc) begin errors++; $display("[TB] FAIL rnd_pc[%0d]: got %h want %h", n, dif.pc_out, m_pc); end
                checks++; if (dif.imm32 !== m_imm) begin errors++; $display("[TB] FAIL rnd_imm[%0d]: got %h want %h", n, dif.imm32, m_imm); end
                checks++; if (dif.opcode !== m_op) begin errors++; $display("[TB] FAIL rnd_opcode[%0d]: got %h want %h", n, dif.opcode, m_op); end
                checks++; if (dif.funct3 !== m_f3) begin errors++; $display("[TB] FAIL rnd_funct3[%0d]: got %h want %h", n, dif.funct3, m_f3); end
                checks++; if (dif.funct7b5 !== m_f7b5) begin errors++; $display("[TB] FAIL rnd_funct7b5[%0d]: got %b want %b", n, dif.funct7b5, m_f7b5); end
            end
            if (m_use1 || (!m_valid && !m_illegal)) begin
                checks++; if (dif.rs1_data !== m_rs1) begin errors++; $display("[TB] FAIL rnd_rs1[%0d]: got %h want %h", n, dif.rs1_data, m_rs1); end
            end
            if (m_use2 || (!m_valid && !m_illegal)) begin
                checks++; if (dif.rs2_data !== m_rs2) begin errors++; $display("[TB] FAIL rnd_rs2[%0d]: got %h want %h", n, dif.rs2_data, m_rs2); end
            end
        end
    endtask

    task automatic test_reset_during_stall();
        set_in(enc_i(OP_IMM, 5'd0, 5'd0, 12'h0), 32'h700, 1, 0, 0, 0);
        tick();
        set_in(enc_i(OP_LOAD, 5'd3, 5'd1, 12'h0), 32'h704, 0, 1, 5'd5, 32'h55AA55AA);
        tick();
        set_in(enc_r(5'd4, 5'd3, 5'd2), 32'h708, 0, 0, 0, 0);
        checks++; if (dif.stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_stall: got %b want 1", dif.stall); end
        rst = 1;
        #1;
        checks++; if (dif.stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_drop: got %b want 0", dif.stall); end
        tick();
        checks++; if ({dif.valid_out, dif.mem_read, dif.illegal, dif.funct7b5} !== 4'b0) begin errors++; $display("[TB] FAIL rst_flags: got %b want 0000", {dif.valid_out, dif.mem_read, dif.illegal, dif.funct7b5}); end
        checks++; if (dif.pc_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %h want 0", dif.pc_out); end
        checks++; if (dif.imm32 !== 32'h0) begin errors++; $display("[TB] FAIL rst_imm: got %h want 0", dif.imm32); end
        checks++; if ({dif.rs1_data, dif.rs2_data} !== 64'h0) begin errors++; $display("[TB] FAIL rst_operands: got %h want 0", {dif.rs1_data, dif.rs2_data}); end
        checks++; if ({dif.rd, dif.opcode, dif.funct3} !== 15'h0) begin errors++; $display("[TB] FAIL rst_fields: got %h want 0", {dif.rd, dif.opcode, dif.funct3}); end
        rst = 0;
        set_in(enc_r(5'd1, 5'd5, 5'd0), 32'h70C, 0, 0, 0, 0);
        tick();
        checks++; if (dif.rs1_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_regs_cleared: got %h want 0", dif.rs1_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        legal_ops = '{OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        m_valid = 0; m_illegal = 0; m_mem_read = 0; m_rd = 0; m_pc = 0;
        m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_op = 0; m_f3 = 0; m_f7b5 = 0;
        m_use1 = 0; m_use2 = 0;
        rst = 1;
        dif.inst = 32'h0; dif.pc_in = 32'h0; dif.flush = 1'b0;
        dif.wb_en = 1'b0; dif.wb_addr = 5'd0; dif.wb_data = 32'h0;
        test_reset();
        test_bypass();
        test_immediates();
        test_load_use();
        test_flush_priority();
        test_illegal();
        test_random();
        test_reset_during_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
- ID stage of the MiniRiscV pipeline, directly downstream of instruction fetch; consumes the fetched 32-bit instruction word each cycle.
- Holds the 32x32 architectural register file with a write-back port, and generates sign-extended immediates.
- Detects load-use hazards and drives `stall` back to fetch.
- Registers all decoded fields into the ID/EX pipeline register for the execute stage.

Parameters:
- XLEN, 32, data/instruction width
- NREG, 32, number of architectural registers (x0 hardwired zero)

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- inst  in  32  instruction word from fetch, valid every cycle
- pc_in  in  32  PC of `inst`
- flush  in  1  taken branch/jump resolved in EX; squash the instruction in ID
- wb_en  in  1  register write-back enable
- wb_addr  in  5  write-back destination
- wb_data  in  32  write-back data
- stall  out  1  combinational; holds fetch for one cycle on load-use
- valid_out  out  1  ID/EX entry holds a real instruction
- pc_out  out  32  registered PC
- rs1_data  out  32  registered rs1 operand
- rs2_data  out  32  registered rs2 operand
- imm32  out  32  registered sign-extended immediate
- rd  out  5  registered destination register
- opcode  out  7  registered opcode
- funct3  out  3  registered funct3
- funct7b5  out  1  registered inst[30]
- mem_read  out  1  registered: instruction is a load
- illegal  out  1  registered: unknown opcode seen

Behaviour:
- Reset:
  - When rst=1 at a posedge, all registered outputs go to 0 and all 32 registers clear to 0 in that same cycle.
  - `stall` is forced to 0 while rst=1.
  - Reset has priority over flush, stall and write-back.
- Register file:
  - Written at posedge when wb_en=1 and wb_addr!=0.
  - Writes to x0 are ignored; reading x0 always returns 0.
  - Write-first bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs1 (or rs2) of the current inst, the read returns wb_data in that cycle.
- Operand usage:
  - rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR.
  - rs2 is used by R, STORE and BRANCH.
  - LUI, AUIPC and JAL use neither operand.
- Immediate (combinational, then registered):
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - I, S, B and J are sign-extended from their top bit; R-type gives 0.
- Load-use hazard:
  - stall = valid_out & mem_read & (rd!=0) & ((uses_rs1 & rs1==rd) | (uses_rs2 & rs2==rd)) & !flush.
  - When stall=1, the next edge loads a bubble into ID/EX (valid_out=0, mem_read=0, rd=0, illegal=0; other fields don't-care but zeroed).
  - The bubble's mem_read=0, so stall self-clears after exactly one cycle.
  - Fetch re-presents the same inst in the next cycle.
- Flush:
  - flush=1 loads a bubble at the next edge regardless of stall.
  - flush overrides stall, and stall is driven 0 during flush.
- Illegal opcode:
  - Any opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111} gives valid_out=0 and illegal=1 (sticky for that entry only).
  - rd is forced to 0 so no write-back and no hazard can occur.
- Normal edge: ID/EX captures the decoded fields with valid_out=1. Latency inst→outputs is 1 cycle.
- Simultaneous write-back to a register that is also the hazard rd: bypass still applies; the stall decision depends only on the ID/EX load.

Decomposition:
- Shared package `riscv_pkg`:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - imm-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE)
  - XLEN constant
- One sub-module `reg_file`:
  - 2 read ports, 1 write port, x0=0, write-first bypass, synchronous active-high clear.
  - Decode logic and the ID/EX register stay in inst_decode.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then read all registers → rs1_data/rs2_data=0; valid_out=0; stall=0; illegal=0.
- Write-back bypass: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF in the same cycle as inst=add x1,x5,x0 → next edge rs1_data=0xDEADBEEF. A write to x0 of 0x1234 followed by a read of x0 → 0.
- Immediates:
  - sw with offset -8 → imm32=0xFFFFFFF8
  - beq with offset +16 → imm32=0x00000010
  - lui 0xABCDE → imm32=0xABCDE000
  - jal with offset -4 → imm32=0xFFFFFFFC
- Load-use:
  - lw x3,0(x1) followed by add x4,x3,x2 → stall=1 for exactly one cycle, a bubble (valid_out=0) enters ID/EX, then add issues with valid_out=1.
  - lw x0 followed by a use of x0 → no stall.
- Flush priority: the load-use condition above with flush=1 asserted in the same cycle → stall=0 and the next ID/EX entry is a bubble.
- Illegal/reset mid-operation:
  - inst=0xFFFFFFFF → illegal=1, valid_out=0, rd=0.
  - rst=1 asserted while stall=1 → stall drops immediately and all outputs are 0 after the edge.
